// File: rtl/mips32_mem_responder.sv
// Memory-side responder for the MIPS32 core: a single-port word memory behind
// a valid/ready request channel and a valid/ready response channel, with a
// fixed number of wait states inserted between acceptance and response.
//
// state  | meaning
// IDLE   | ready for a new request; access is committed at the accept edge
// WAIT   | counting down the programmed wait states
// RESP   | response presented, held until the initiator takes it
module mips32_mem_responder #(
  parameter int ADDR_W  = 10,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [31:0]       i_req_wdata,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [31:0]       o_rsp_rdata,
  output logic              o_rsp_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Counter is loaded with LATENCY-1 so that WAIT lasts exactly LATENCY cycles.
  localparam logic [3:0]      LAT_M1    = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_cnt;
  logic [31:0]      r_rdata;
  logic             r_err;
  logic [31:0]      r_mem [DEPTH];
  logic             w_accept;
  logic             w_in_range;
  logic [IDX_W-1:0] w_idx;

  assign w_in_range = ({1'b0, i_req_addr} < DEPTH_LIM);
  assign w_idx      = i_req_addr[IDX_W-1:0];
  assign w_accept   = o_req_ready & i_req_valid;

  // State register and wait-state down-counter.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_cnt <= LAT_M1;
      end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = (LATENCY > 0) ? S_WAIT : S_RESP;
      S_WAIT: if (r_cnt == 4'd0) w_state_nxt = S_RESP;
      S_RESP: if (i_rsp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs: ready only in IDLE outside reset, response fields zero unless in RESP.
  always_comb begin
    o_req_ready = (r_state == S_IDLE) && !i_reset;
    o_rsp_valid = (r_state == S_RESP);
    o_rsp_rdata = (r_state == S_RESP) ? r_rdata : 32'd0;
    o_rsp_err   = (r_state == S_RESP) ? r_err : 1'b0;
  end

  // Storage write at the accept edge; contents survive reset.
  always_ff @(posedge i_clk) begin
    if (w_accept && i_req_we && w_in_range) begin
      r_mem[w_idx] <= i_req_wdata;
    end
  end

  // Capture the access outcome at the accept edge; later req_* changes are ignored.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_err   <= !w_in_range;
      r_rdata <= (!i_req_we && w_in_range) ? r_mem[w_idx] : 32'd0;
    end
  end

endmodule

// File: tb/tb_mips32_mem_responder.sv
// Bench for mips32_mem_responder: instance 0 has LATENCY=2 / DEPTH=1000,
// instance 1 has LATENCY=0 / DEPTH=1024. A transaction-level model tracks
// memory contents and cycles since acceptance and is compared every cycle.
module tb_mips32_mem_responder;

  logic        clk = 1'b0;
  logic [1:0]  rst;
  logic [1:0]  req_valid, req_we, rsp_ready;
  logic [9:0]  req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [1:0]  req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata [2];

  int     n_chk  = 0;
  int     n_pass = 0;
  bit     done   = 1'b0;
  longint cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mips32_mem_responder #(.ADDR_W(10), .DEPTH(1000), .LATENCY(2)) u_a (
    .i_clk(clk), .i_reset(rst[0]), .i_req_valid(req_valid[0]), .o_req_ready(req_ready[0]),
    .i_req_we(req_we[0]), .i_req_addr(req_addr[0]), .i_req_wdata(req_wdata[0]),
    .o_rsp_valid(rsp_valid[0]), .i_rsp_ready(rsp_ready[0]),
    .o_rsp_rdata(rsp_rdata[0]), .o_rsp_err(rsp_err[0]));

  mips32_mem_responder #(.ADDR_W(10), .DEPTH(1024), .LATENCY(0)) u_b (
    .i_clk(clk), .i_reset(rst[1]), .i_req_valid(req_valid[1]), .o_req_ready(req_ready[1]),
    .i_req_we(req_we[1]), .i_req_addr(req_addr[1]), .i_req_wdata(req_wdata[1]),
    .o_rsp_valid(rsp_valid[1]), .i_rsp_ready(rsp_ready[1]),
    .o_rsp_rdata(rsp_rdata[1]), .o_rsp_err(rsp_err[1]));

  function automatic int lat_of(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  function automatic int depth_of(input int i);
    return (i == 0) ? 1000 : 1024;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic timeout(input string nm);
    n_chk++;
    $display("FAIL %s: timed out waiting for DUT", nm);
  endtask

  // Transaction-level model: memory image plus edges elapsed since acceptance.
  logic [31:0] m_mem   [2][1024];
  bit          m_known [2][1024];
  bit          m_init  [2];
  bit          m_idle  [2];
  int          m_p     [2];
  logic [31:0] m_rd    [2];
  bit          m_err   [2];
  bit          m_chkd  [2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_init[i] = 0; m_idle[i] = 1; m_p[i] = 0;
      for (int a = 0; a < 1024; a++) m_known[i][a] = 0;
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst[i]) begin
        m_init[i] <= 1; m_idle[i] <= 1; m_p[i] <= 0;
      end else if (m_init[i]) begin
        if (!m_idle[i]) begin
          if (m_p[i] >= lat_of(i) && rsp_ready[i]) m_idle[i] <= 1;
          else if (m_p[i] < 100) m_p[i] <= m_p[i] + 1;
        end else if (req_valid[i]) begin
          m_idle[i] <= 0;
          m_p[i]    <= 0;
          m_err[i]  <= (int'(req_addr[i]) >= depth_of(i));
          if (int'(req_addr[i]) >= depth_of(i)) begin
            m_rd[i] <= 32'd0; m_chkd[i] <= 1;
          end else if (req_we[i]) begin
            m_mem[i][req_addr[i]]   <= req_wdata[i];
            m_known[i][req_addr[i]] <= 1;
            m_rd[i] <= 32'd0; m_chkd[i] <= 1;
          end else begin
            m_rd[i]   <= m_mem[i][req_addr[i]];
            m_chkd[i] <= m_known[i][req_addr[i]];
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (m_init[i] && !done) begin
        chk($sformatf("u%0d req_ready", i), {31'd0, req_ready[i]},
            {31'd0, (!rst[i] && m_idle[i])});
        chk($sformatf("u%0d rsp_valid", i), {31'd0, rsp_valid[i]},
            {31'd0, (!m_idle[i] && m_p[i] >= lat_of(i))});
        if (m_idle[i]) begin
          chk($sformatf("u%0d idle rdata", i), rsp_rdata[i], 32'd0);
          chk($sformatf("u%0d idle err", i), {31'd0, rsp_err[i]}, 32'd0);
        end else if (m_p[i] >= lat_of(i)) begin
          chk($sformatf("u%0d rsp err", i), {31'd0, rsp_err[i]}, {31'd0, m_err[i]});
          if (m_chkd[i]) chk($sformatf("u%0d rsp rdata", i), rsp_rdata[i], m_rd[i]);
        end
      end
    end
  end

  // Runs one access. Entered and left at posedge+2. 'early' raises rsp_ready
  // from acceptance on; 'keep' holds req_valid with scrambled fields after accept.
  task automatic txn(input int i, input bit we, input logic [9:0] a, input logic [31:0] d,
                     input bit early, input bit keep, input int hold,
                     output int lat, output logic [31:0] rd, output logic er,
                     output longint acc);
    int  n;
    bit  ok;
    lat = 0; rd = 32'd0; er = 1'b0; acc = 0;
    req_valid[i] = 1'b1; req_we[i] = we; req_addr[i] = a; req_wdata[i] = d;
    ok = 0; n = 0;
    while (!ok && n < 40) begin
      @(negedge clk); n++; ok = req_ready[i];
    end
    if (!ok) begin
      timeout($sformatf("u%0d accept", i));
      req_valid[i] = 1'b0;
      @(posedge clk); #2;
      return;
    end
    @(posedge clk); #2;
    acc = cyc;
    if (keep) begin
      req_we[i] = ~we; req_addr[i] = a ^ 10'h155; req_wdata[i] = ~d;
    end else begin
      req_valid[i] = 1'b0;
    end
    if (early) rsp_ready[i] = 1'b1;
    ok = 0; n = 0;
    while (!ok && n < 40) begin
      @(negedge clk); n++; ok = rsp_valid[i];
    end
    if (!ok) begin
      timeout($sformatf("u%0d response", i));
      req_valid[i] = 1'b0; rsp_ready[i] = 1'b0;
      @(posedge clk); #2;
      return;
    end
    lat = n; rd = rsp_rdata[i]; er = rsp_err[i];
    if (!early) begin
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        chk("hold rsp_valid", {31'd0, rsp_valid[i]}, 32'd1);
        chk("hold req_ready", {31'd0, req_ready[i]}, 32'd0);
      end
      #2 rsp_ready[i] = 1'b1;
    end
    @(posedge clk); #2;
    rsp_ready[i] = 1'b0; req_valid[i] = 1'b0;
  endtask

  int          lat;
  logic [31:0] rd;
  logic        er;
  longint      acc0, acc1;

  initial begin
    rst = 2'b11; req_valid = '0; req_we = '0; rsp_ready = '0;
    for (int i = 0; i < 2; i++) begin req_addr[i] = '0; req_wdata[i] = '0; end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset req_ready a", {31'd0, req_ready[0]}, 32'd0);
    chk("reset req_ready b", {31'd0, req_ready[1]}, 32'd0);
    @(posedge clk); #2 rst = 2'b00;

    // Instance 0: LATENCY=2, DEPTH=1000
    txn(0, 1, 10'd5, 32'hDEADBEEF, 0, 0, 0, lat, rd, er, acc0);
    chk("wr5 latency", lat, 3); chk("wr5 rdata", rd, 32'd0); chk("wr5 err", {31'd0, er}, 32'd0);
    txn(0, 0, 10'd5, 32'h0, 0, 0, 0, lat, rd, er, acc0);
    chk("rd5 latency", lat, 3); chk("rd5 rdata", rd, 32'hDEADBEEF);

    txn(0, 1, 10'd9, 32'hA5A5A5A5, 0, 0, 0, lat, rd, er, acc0);
    txn(0, 0, 10'd9, 32'h0, 0, 0, 5, lat, rd, er, acc0);
    chk("bp rdata", rd, 32'hA5A5A5A5); chk("bp err", {31'd0, er}, 32'd0);

    txn(0, 1, 10'd999, 32'h11223344, 0, 0, 0, lat, rd, er, acc0);
    chk("wr999 err", {31'd0, er}, 32'd0);
    txn(0, 1, 10'd1000, 32'hFFFFFFFF, 0, 0, 0, lat, rd, er, acc0);
    chk("wr1000 err", {31'd0, er}, 32'd1); chk("wr1000 rdata", rd, 32'd0);
    txn(0, 0, 10'd1000, 32'h0, 0, 0, 0, lat, rd, er, acc0);
    chk("rd1000 err", {31'd0, er}, 32'd1); chk("rd1000 rdata", rd, 32'd0);
    txn(0, 0, 10'd999, 32'h0, 0, 0, 0, lat, rd, er, acc0);
    chk("rd999 rdata", rd, 32'h11223344); chk("rd999 err", {31'd0, er}, 32'd0);

    // Reset while a write to addr 7 is waiting
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 10'd7; req_wdata[0] = 32'h42;
    @(negedge clk);
    chk("rst-test accept ready", {31'd0, req_ready[0]}, 32'd1);
    @(posedge clk); #2 req_valid[0] = 1'b0;
    @(posedge clk); #2 rst[0] = 1'b1;
    @(negedge clk);
    chk("mid-reset req_ready", {31'd0, req_ready[0]}, 32'd0);
    chk("mid-reset rsp_valid", {31'd0, rsp_valid[0]}, 32'd0);
    @(posedge clk); #2;
    @(negedge clk);
    chk("reset held rsp_valid", {31'd0, rsp_valid[0]}, 32'd0);
    @(posedge clk); #2 rst[0] = 1'b0;
    @(negedge clk);
    chk("post-reset req_ready", {31'd0, req_ready[0]}, 32'd1);
    chk("post-reset rsp_valid", {31'd0, rsp_valid[0]}, 32'd0);
    @(posedge clk); #2;
    txn(0, 0, 10'd7, 32'h0, 0, 0, 0, lat, rd, er, acc0);
    chk("rd7 after reset", rd, 32'h00000042);

    // Request fields change / valid held while waiting
    txn(0, 1, 10'd3, 32'hCAFEF00D, 0, 1, 0, lat, rd, er, acc0);
    chk("wr3 keep err", {31'd0, er}, 32'd0);
    txn(0, 0, 10'd3, 32'h0, 0, 1, 0, lat, rd, er, acc0);
    chk("rd3 keep rdata", rd, 32'hCAFEF00D); chk("rd3 keep latency", lat, 3);
    txn(0, 0, 10'd5, 32'h0, 1, 0, 0, lat, rd, er, acc0);
    txn(0, 0, 10'd5, 32'h0, 1, 0, 0, lat, rd, er, acc1);
    chk("lat2 throughput", 32'(acc1 - acc0), 32'd4); chk("rd5 again", rd, 32'hDEADBEEF);

    // Instance 1: LATENCY=0, DEPTH=1024
    txn(1, 1, 10'd0, 32'h12345678, 1, 0, 0, lat, rd, er, acc0);
    txn(1, 0, 10'd0, 32'h0, 1, 0, 0, lat, rd, er, acc0);
    chk("l0 rd0 latency", lat, 1); chk("l0 rd0 rdata", rd, 32'h12345678);
    txn(1, 0, 10'd0, 32'h0, 1, 0, 0, lat, rd, er, acc1);
    chk("l0 throughput", 32'(acc1 - acc0), 32'd2); chk("l0 rd0 again", rd, 32'h12345678);
    txn(1, 1, 10'd1023, 32'h0BADF00D, 0, 0, 2, lat, rd, er, acc0);
    chk("l0 wr1023 err", {31'd0, er}, 32'd0);
    txn(1, 0, 10'd1023, 32'h0, 0, 0, 0, lat, rd, er, acc0);
    chk("l0 rd1023 rdata", rd, 32'h0BADF00D); chk("l0 rd1023 latency", lat, 1);

    repeat (3) @(posedge clk);
    done = 1'b1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mips32_mem_responder.md
Name: mips32_mem_responder

Overview:
- Memory-side responder for the MIPS32 core's load/store and fetch traffic: a single-port, word-addressed 32-bit memory behind a valid/ready request channel and a valid/ready response channel.
- Inserts a programmable number of wait states per access, so the pipeline can be exercised against realistic memory latency.
- Sits between the core's memory-request initiator and the backing storage, replacing the core's direct array access.

Parameters:
- ADDR_W, 10, request address width (word address).
- DEPTH, 1024, number of implemented 32-bit words; must be ≤ 2^ADDR_W.
- LATENCY, 2, wait cycles between request acceptance and response; legal range 0..15.

Ports:
- clk  input  1  single system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  initiator presents a request.
- req_ready  output  1  responder can accept a request this cycle.
- req_we  input  1  1 = store (write), 0 = load/fetch (read).
- req_addr  input  ADDR_W  word address.
- req_wdata  input  32  store data.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  initiator consumes response.
- rsp_rdata  output  32  load data; 0 for writes and errors.
- rsp_err  output  1  address ≥ DEPTH.

Behaviour:
- One clock (clk); reset is synchronous and active-high. Reset is sampled on the rising edge of clk.
- Reset values:
  - req_ready = 0 while reset is asserted.
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, state = IDLE, wait counter = 0.
  - Memory contents are not cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - Accept on a rising edge where req_valid & req_ready.
  - Latch we/addr/wdata at acceptance.
  - Go to WAIT if LATENCY > 0, else go to RESP.
- Access commit at the acceptance edge:
  - Write to an in-range address: mem[addr] ← req_wdata.
  - Read: data captured from mem[addr] at that edge.
  - Out-of-range address (addr ≥ DEPTH): no memory write; data 0; error flag set.
- WAIT:
  - req_ready = 0.
  - Counter loads LATENCY−1 on entry and decrements each cycle.
  - Go to RESP when the counter is 0.
- Latency: rsp_valid first rises exactly LATENCY+1 cycles after the acceptance edge.
  - LATENCY = 0 → 1 cycle.
  - LATENCY = 2 → 3 cycles.
- RESP:
  - rsp_valid = 1.
  - rsp_rdata: read data, or 0 for writes and errors.
  - rsp_err: error flag.
  - req_ready = 0.
  - rsp_rdata and rsp_err are held stable while rsp_valid & !rsp_ready (backpressure, any duration).
- On rsp_valid & rsp_ready:
  - Return to IDLE.
  - rsp_valid, rsp_rdata and rsp_err drop to 0 the next cycle.
  - req_ready rises the next cycle; there is no same-cycle re-accept.
  - Maximum throughput: one access per LATENCY+2 cycles.
- Only one outstanding request at a time. req_* inputs are ignored unless in IDLE.
- A write followed by a read of the same address returns the new data (read-after-write ordering is guaranteed by serialisation).
- Reset mid-operation:
  - Any outstanding request is dropped with no response issued.
  - A write already committed at acceptance remains in memory.
  - The FSM returns to IDLE.
- rsp_ready asserted outside RESP has no effect.
- req_valid held high across a response is not re-accepted until IDLE.

Test Plan:
- Reset, then write 0xDEADBEEF to addr 5, LATENCY=2 → rsp_valid rises 3 cycles after accept, rsp_rdata=0, rsp_err=0; then read addr 5 → rsp_rdata=0xDEADBEEF after 3 cycles.
- LATENCY=0 build: read addr 0 preloaded with 0x12345678 → rsp_valid exactly 1 cycle after accept, rdata 0x12345678; back-to-back reads accepted every 2 cycles.
- Backpressure: hold rsp_ready=0 for 5 cycles during a read of 0xA5A5A5A5 → rsp_valid, rsp_rdata and rsp_err stable throughout, req_ready=0; release → one handshake, req_ready=1 the next cycle.
- DEPTH=1000 build: write 0xFFFFFFFF to addr 1000 → rsp_err=1, rdata=0; read addr 1000 → rsp_err=1, rdata=0; read addr 999 → prior contents unchanged.
- Assert reset during WAIT of a write of 0x00000042 to addr 7 → no rsp_valid, req_ready=0 during reset then 1; subsequent read of addr 7 returns 0x00000042.
- Change req_addr/req_wdata while in WAIT → response reflects only the latched values; exactly one response per accepted request.
